// File: rtl/fast_base_conv_q2b_pkg.sv
// Shared RNS constants and types for the q-basis to B-basis fast base conversion.
// Limb index 0 sits in the least-significant element of every packed array.
package fast_base_conv_q2b_pkg;

    localparam int N_SLOTS = 4;
    localparam int QLEN    = 2;
    localparam int BLEN    = 2;
    localparam int COEFF_W = 8;
    localparam int WIDE_W  = 2 * COEFF_W;
    localparam int JW      = (QLEN > 1) ? $clog2(QLEN) : 1;

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef logic [WIDE_W-1:0]  wide_t;

    typedef coeff_t [QLEN-1:0]         q_BASIS_res;
    typedef coeff_t [BLEN-1:0]         B_BASIS_res;
    typedef q_BASIS_res [N_SLOTS-1:0]  q_BASIS_poly;
    typedef B_BASIS_res [N_SLOTS-1:0]  B_BASIS_poly;

    localparam logic [QLEN-1:0][COEFF_W-1:0] q_BASIS = {8'd11, 8'd7};
    localparam logic [BLEN-1:0][COEFF_W-1:0] B_BASIS = {8'd17, 8'd13};

    // (q/q_j)^-1 mod q_j and (q/q_j) mod B_k for the basis pair above.
    localparam logic [QLEN-1:0][COEFF_W-1:0] QHAT_INV_MOD_Q = {8'd8, 8'd2};
    localparam logic [QLEN-1:0][BLEN-1:0][COEFF_W-1:0] QHAT_MOD_B =
        {{8'd7, 8'd7}, {8'd11, 8'd11}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } fbc_state_e;

    // Operands are already below m, so one conditional subtract fully reduces the sum.
    function automatic coeff_t mod_add(input coeff_t a, input coeff_t b, input coeff_t m);
        logic [COEFF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[COEFF_W-1:0];
    endfunction

endpackage

// File: rtl/fast_base_conv_q2b_mac.sv
// One slot's worth of FastBConv work for a single q limb: scale the residue by
// qhat^-1, then fold y*qhat into every B-limb accumulator in parallel.
module fbc_limb_mac
    import fast_base_conv_q2b_pkg::*;
(
    input  q_BASIS_res       x_res,
    input  logic [JW-1:0]    limb_idx,
    input  B_BASIS_res       acc_in,
    output B_BASIS_res       acc_out
);

    wide_t y_prod;
    wide_t y;
    wide_t term;

    always_comb begin
        y_prod  = wide_t'(x_res[limb_idx]) * wide_t'(QHAT_INV_MOD_Q[limb_idx]);
        y       = y_prod % wide_t'(q_BASIS[limb_idx]);
        term    = '0;
        acc_out = '0;
        for (int k = 0; k < BLEN; k++) begin
            term       = (y * wide_t'(QHAT_MOD_B[limb_idx][k])) % wide_t'(B_BASIS[k]);
            acc_out[k] = mod_add(acc_in[k], term[COEFF_W-1:0], B_BASIS[k]);
        end
    end

endmodule

// File: rtl/fast_base_conv_q2b.sv
// Sequential BEHZ fast base conversion: walks the q limbs one per cycle and
// emits the approximate B-basis residues (x + a*q, a < QLEN) for every slot.
module fast_base_conv_q2b
    import fast_base_conv_q2b_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  q_BASIS_poly in_poly,
    output logic        out_valid,
    input  logic        out_ready,
    output B_BASIS_poly out_poly
);

    fbc_state_e    state;
    q_BASIS_poly   in_reg;
    B_BASIS_poly   acc;
    B_BASIS_poly   acc_next;
    logic [JW-1:0] limb;

    for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
        fbc_limb_mac u_mac (
            .x_res    (in_reg[s]),
            .limb_idx (limb),
            .acc_in   (acc[s]),
            .acc_out  (acc_next[s])
        );
    end

    // in_ready mirrors IDLE, so anything offered during ACCUM/DONE simply waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            in_reg    <= '0;
            acc       <= '0;
            limb      <= '0;
            out_poly  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg   <= in_poly;
                        acc      <= '0;
                        limb     <= '0;
                        in_ready <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    if (limb == JW'(QLEN - 1)) begin
                        limb      <= '0;
                        out_poly  <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        limb <= limb + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fast_base_conv_q2b.md
Name: fast_base_conv_q2b

Overview:
- Sequential RNS fast base conversion (BEHZ FastBConv): takes a polynomial in the q basis and produces the same coefficients in the B basis.
- Sits directly downstream of the RNS polynomial multiplier's q-basis output.
- Feeds the B-basis datapath used by tensoring and rescale.
- Approximate conversion: each output coefficient equals x + a*q, with 0 <= a < q_BASIS_LEN. No correction of a is performed here.

Parameters:
- N_SLOTS, `N_SLOTS, coefficients per polynomial (global macro, not overridable).
- QLEN, `q_BASIS_LEN, number of q limbs iterated.
- BLEN, `B_BASIS_LEN, number of B limbs produced in parallel.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input poly valid
- in_ready  out  1  block can accept input
- in_poly  in  q_BASIS_poly  input residues, each < q_BASIS[j]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_poly  out  B_BASIS_poly  converted residues, each < B_BASIS[k]

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - out_poly, accumulators and limb counter cleared to 0.
- Input handshake: capture in_poly into the input register when in_valid && in_ready.
- FSM IDLE:
  - in_ready = 1.
  - On handshake: clear accumulators, j <= 0, go to ACCUM.
- FSM ACCUM (one q limb per cycle, for every slot i and every B limb k in parallel):
  - y = (x[i][j] * QHAT_INV_MOD_Q[j]) mod q_BASIS[j].
  - acc[i][k] <= (acc[i][k] + (y * QHAT_MOD_B[j][k]) mod B_BASIS[k]) mod B_BASIS[k].
  - Final add reduced by a single conditional subtract, so acc stays < B_BASIS[k].
  - j increments each cycle. After j = QLEN-1 is processed, go to DONE.
  - in_ready = 0 throughout.
- FSM DONE:
  - out_valid = 1; out_poly driven directly from acc (registered).
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - out_poly and out_valid held stable while out_ready = 0.
- Latency: in-handshake cycle T → out_valid asserted at T+QLEN+1.
- Throughput: one poly per QLEN+2 cycles minimum, including the DONE→IDLE cycle.
- in_ready is only 1 in IDLE. Input arriving during ACCUM/DONE is backpressured, never dropped or overwritten.
- Products: y*QHAT uses 2*coeff-width intermediates (the wide typedefs), reduced by % in the same cycle.
- Zero input gives an all-zero output.
- Reset asserted mid-ACCUM/DONE: immediate abort to reset values; the partial result is discarded.
- in_valid held through reset: accepted on the first IDLE clock after deassertion.

Decomposition:
- Shared package/types.svh gains:
  - QHAT_INV_MOD_Q[QLEN]: (q/q_j)^-1 mod q_j.
  - QHAT_MOD_B[QLEN][BLEN]: (q/q_j) mod B_k.
  - Both generated alongside q_BASIS/B_BASIS.
- Reuse the existing q_BASIS_poly, B_BASIS_poly and wide_* typedefs; no new poly types.
- One natural sub-module: fbc_limb_mac (combinational y computation plus per-B-limb multiply-accumulate-reduce), instantiated per slot.
- FSM, counter and handshake stay in the top module.

Test Plan (toy config q_BASIS = {7,11}, B_BASIS = {13,17}; QHAT_INV_MOD_Q = {2,8}; QHAT_MOD_B = {{11,11},{7,7}}):
- Slot residues (5,5), x = 5 → out (4,14) (= 82 = 5+77, one-q overflow expected), out_valid at T+3.
- Slot residues (6,10), x = 76 → out (11,8), exact result.
- All-zero poly → all-zero out; out_valid at T+3.
- out_ready held 0 for 10 cycles after DONE → out_poly stable, in_ready = 0, second in_valid not accepted. Release → out handshake, then IDLE, then the second poly is accepted.
- rst_n pulsed low during ACCUM (j = 1) → out_valid = 0 and in_ready = 1 immediately. A new poly then converts correctly, with no carry-over from the aborted acc.
- Back-to-back: in_valid always 1, out_ready always 1 → one result per 4 cycles, values matching a reference model over 1000 random polys.
